pipeline_hold_ctrl: RTL and testbench
=====================================

Name: pipeline_hold_ctrl

Overview:
- Central hazard/hold controller for the 5-stage core.
- Arbitrates hazard sources into per-stage 3-bit hold-flag codes that drive every hold-aware pipeline register: trap, data-memory wait, divider busy, jump, load-use and fetch wait.
- Source priority in RUN: trap > memory wait > divider > jump > load-use > fetch wait.
- Sequences multi-cycle stalls with an FSM, supplies the PC redirect, keeps a stall-cycle counter and a hang watchdog.

Parameters:
- ADDR_WIDTH, 64, width of redirect/trap/jump addresses.
- MAX_WAIT, 1024, watchdog limit in cycles for DIV_BUSY/MEM_WAIT (≥2).
- CNT_WIDTH, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- trap_req  in  1  exception/interrupt taken.
- trap_addr  in  ADDR_WIDTH  trap vector.
- mem_req  in  1  MEM-stage load/store outstanding.
- mem_ready  in  1  data memory response.
- div_start  in  1  EX issues a divide.
- div_done  in  1  divider result valid.
- jump_req  in  1  EX resolved taken branch/jump.
- jump_addr  in  ADDR_WIDTH  branch/jump target.
- load_use_req  in  1  ID depends on a load in EX.
- ifu_ready  in  1  fetch data valid.
- pc_flag  out  3  PC register code.
- ifid_flag  out  3  IF/ID register code.
- idex_flag  out  3  ID/EX register code.
- exmem_flag  out  3  EX/MEM register code.
- memwb_flag  out  3  MEM/WB register code.
- redirect_valid  out  1  PC loads redirect_addr.
- redirect_addr  out  ADDR_WIDTH  new PC.
- stall_cnt  out  CNT_WIDTH  cycles with pc_flag≠000.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Codes:
  - 000 run.
  - 001 flush (bubble).
  - 010 short hold.
  - 011 trap flush.
  - 100 long hold.
  - Consumers treat 001 and 011 as clear, 010 and 100 as keep.
- Timing: flags and redirect are combinational from state and current inputs, so the registers act at the next clk edge. Zero added latency.
- While rst is high:
  - All flags = 001.
  - redirect_valid = 0, redirect_addr = 0.
  - State RUN; stall_cnt, wait counter and timeout_err cleared.
- FSM state RUN — apply the first matching case:
  - trap_req: redirect_valid = 1, addr = trap_addr; pc 000, ifid/idex/exmem 011, memwb 000. State stays RUN.
  - mem_req & !mem_ready: enter MEM_WAIT; apply the MEM_WAIT outputs this cycle.
  - div_start & !div_done: enter DIV_BUSY; apply the DIV_BUSY outputs this cycle.
  - jump_req: redirect to jump_addr; pc 000, ifid 001, idex 001, others 000. Overrides load_use_req and ifu_ready.
  - load_use_req: pc 010, ifid 010, idex 001, others 000.
  - !ifu_ready: pc 010, ifid 001, others 000.
  - Otherwise: all 000.
- MEM_WAIT:
  - pc/ifid/idex/exmem 100, memwb 001.
  - On mem_ready: all 000 that cycle, return to RUN.
- DIV_BUSY:
  - pc/ifid/idex 100, exmem 001, memwb 000.
  - On div_done: all 000, return to RUN.
- Deferred events: trap_req and jump_req during MEM_WAIT/DIV_BUSY are ignored. Sources hold the request until RUN, which keeps traps precise.
- Watchdog:
  - Counter increments each cycle in MEM_WAIT/DIV_BUSY; clears on entry to RUN.
  - On reaching MAX_WAIT, in that cycle: timeout_err set (sticky until reset), ifid/idex/exmem 011, memwb 001, pc 010, state returns to RUN.
  - A done/ready arriving in the same cycle wins: normal exit, no error.
- stall_cnt: increments on every cycle with pc_flag ∈ {010, 100}; saturates at all-ones.
- redirect_addr = 0 whenever redirect_valid = 0.

Test Plan:
- Reset: assert rst mid-MEM_WAIT asynchronously → all flags 001 immediately; after release state RUN, stall_cnt = 0, flags 000 with idle inputs.
- Load-use: load_use_req=1 for 1 cycle → pc 010, ifid 010, idex 001; next cycle all 000; stall_cnt = 1.
- Jump beats load-use: jump_req=1, jump_addr=0x8000_0100, load_use_req=1 → redirect_valid=1, addr 0x8000_0100, ifid 001, idex 001, pc 000.
- Divide: div_start at cycle 0, div_done at cycle 34 → cycles 0–33 pc/ifid/idex 100, exmem 001; cycle 34 all 000; stall_cnt = 34. A trap_req held from cycle 5 is taken only at cycle 35 (ifid/idex/exmem 011, redirect to trap_addr).
- Memory wait: mem_req=1, mem_ready low 3 cycles → 3 cycles pc..exmem 100, memwb 001; 4th cycle mem_ready=1 gives all 000.
- Watchdog with MAX_WAIT=8: div_start, no div_done → at 8th busy cycle timeout_err=1, ifid/idex/exmem 011; next cycle state RUN, timeout_err stays 1 until rst.

Source files
------------

// File: rtl/pipeline_hold_ctrl.sv
// Central hazard/hold controller: arbitrates stall sources into per-stage
// hold-flag codes, sequences long stalls and supplies the PC redirect.
module pipeline_hold_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_WAIT   = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_addr,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  div_start,
  input  logic                  div_done,
  input  logic                  jump_req,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  load_use_req,
  input  logic                  ifu_ready,
  output logic [2:0]            pc_flag,
  output logic [2:0]            ifid_flag,
  output logic [2:0]            idex_flag,
  output logic [2:0]            exmem_flag,
  output logic [2:0]            memwb_flag,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic                  timeout_err
);

  localparam logic [2:0] F_RUN  = 3'b000;
  localparam logic [2:0] F_BUB  = 3'b001;
  localparam logic [2:0] F_HOLD = 3'b010;
  localparam logic [2:0] F_TRAP = 3'b011;
  localparam logic [2:0] F_LONG = 3'b100;

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM,
    S_DIV
  } state_e;

  state_e               state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 wd_hit;
  logic                 wd_fire;
  logic                 stall;

  // wait_q counts busy cycles already completed; this cycle is number wait_q+1
  assign wd_hit = (wait_q == WW'(MAX_WAIT - 1));

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    err_d          = err_q;
    wd_fire        = 1'b0;
    pc_flag        = F_RUN;
    ifid_flag      = F_RUN;
    idex_flag      = F_RUN;
    exmem_flag     = F_RUN;
    memwb_flag     = F_RUN;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    if (rst) begin
      pc_flag    = F_BUB;
      ifid_flag  = F_BUB;
      idex_flag  = F_BUB;
      exmem_flag = F_BUB;
      memwb_flag = F_BUB;
      state_d    = S_RUN;
      wait_d     = '0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          wait_d = '0;
          priority case (1'b1)
            trap_req: begin
              redirect_valid = 1'b1;
              redirect_addr  = trap_addr;
              ifid_flag      = F_TRAP;
              idex_flag      = F_TRAP;
              exmem_flag     = F_TRAP;
            end
            mem_req && !mem_ready: begin
              state_d    = S_MEM;
              wait_d     = WW'(1);
              pc_flag    = F_LONG;
              ifid_flag  = F_LONG;
              idex_flag  = F_LONG;
              exmem_flag = F_LONG;
              memwb_flag = F_BUB;
            end
            div_start && !div_done: begin
              state_d    = S_DIV;
              wait_d     = WW'(1);
              pc_flag    = F_LONG;
              ifid_flag  = F_LONG;
              idex_flag  = F_LONG;
              exmem_flag = F_BUB;
            end
            jump_req: begin
              redirect_valid = 1'b1;
              redirect_addr  = jump_addr;
              ifid_flag      = F_BUB;
              idex_flag      = F_BUB;
            end
            load_use_req: begin
              pc_flag   = F_HOLD;
              ifid_flag = F_HOLD;
              idex_flag = F_BUB;
            end
            !ifu_ready: begin
              pc_flag   = F_HOLD;
              ifid_flag = F_BUB;
            end
            default: ;
          endcase
        end
        S_MEM, S_DIV: begin
          if ((state_q == S_MEM) ? mem_ready : div_done) begin
            state_d = S_RUN;
            wait_d  = '0;
          end else if (wd_hit) begin
            wd_fire    = 1'b1;
            err_d      = 1'b1;
            state_d    = S_RUN;
            wait_d     = '0;
            pc_flag    = F_HOLD;
            ifid_flag  = F_TRAP;
            idex_flag  = F_TRAP;
            exmem_flag = F_TRAP;
            memwb_flag = F_BUB;
          end else begin
            wait_d    = wait_q + WW'(1);
            pc_flag   = F_LONG;
            ifid_flag = F_LONG;
            idex_flag = F_LONG;
            if (state_q == S_MEM) begin
              exmem_flag = F_LONG;
              memwb_flag = F_BUB;
            end else begin
              exmem_flag = F_BUB;
            end
          end
        end
        default: begin
          state_d = S_RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  assign stall = (pc_flag == F_HOLD) || (pc_flag == F_LONG);

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt   = cnt_q;
  assign timeout_err = err_q | wd_fire;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl: default instance plus a
// MAX_WAIT=8 instance for the watchdog scenarios.
module tb_pipeline_hold_ctrl;

  localparam int AW = 64;
  localparam int CW = 32;

  localparam logic [14:0] F_IDLE = 15'b000_000_000_000_000;
  localparam logic [14:0] F_RST  = 15'b001_001_001_001_001;
  localparam logic [14:0] F_MEM  = 15'b100_100_100_100_001;
  localparam logic [14:0] F_DIV  = 15'b100_100_100_001_000;
  localparam logic [14:0] F_LU   = 15'b010_010_001_000_000;
  localparam logic [14:0] F_FW   = 15'b010_001_000_000_000;
  localparam logic [14:0] F_JMP  = 15'b000_001_001_000_000;
  localparam logic [14:0] F_TRAP = 15'b000_011_011_011_000;
  localparam logic [14:0] F_TO   = 15'b010_011_011_011_001;

  logic          clk = 1'b0;
  logic          rst;
  logic          trap_req;
  logic [AW-1:0] trap_addr;
  logic          mem_req;
  logic          mem_ready;
  logic          div_start;
  logic          div_done;
  logic          jump_req;
  logic [AW-1:0] jump_addr;
  logic          load_use_req;
  logic          ifu_ready;

  logic [2:0]    pc_f, ifid_f, idex_f, exmem_f, memwb_f;
  logic          rv;
  logic [AW-1:0] ra;
  logic [CW-1:0] scnt;
  logic          terr;

  logic [2:0]    w_pc, w_ifid, w_idex, w_exmem, w_memwb;
  logic          w_rv;
  logic [AW-1:0] w_ra;
  logic [CW-1:0] w_scnt;
  logic          w_terr;

  logic [14:0]   fl;
  logic [14:0]   wfl;

  int checks = 0;
  int errors = 0;

  assign fl  = {pc_f, ifid_f, idex_f, exmem_f, memwb_f};
  assign wfl = {w_pc, w_ifid, w_idex, w_exmem, w_memwb};

  always #5 clk = ~clk;

  pipeline_hold_ctrl #(
    .ADDR_WIDTH(AW), .MAX_WAIT(1024), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_addr(trap_addr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .div_start(div_start), .div_done(div_done),
    .jump_req(jump_req), .jump_addr(jump_addr),
    .load_use_req(load_use_req), .ifu_ready(ifu_ready),
    .pc_flag(pc_f), .ifid_flag(ifid_f), .idex_flag(idex_f),
    .exmem_flag(exmem_f), .memwb_flag(memwb_f),
    .redirect_valid(rv), .redirect_addr(ra),
    .stall_cnt(scnt), .timeout_err(terr)
  );

  pipeline_hold_ctrl #(
    .ADDR_WIDTH(AW), .MAX_WAIT(8), .CNT_WIDTH(CW)
  ) dut_wd (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_addr(trap_addr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .div_start(div_start), .div_done(div_done),
    .jump_req(jump_req), .jump_addr(jump_addr),
    .load_use_req(load_use_req), .ifu_ready(ifu_ready),
    .pc_flag(w_pc), .ifid_flag(w_ifid), .idex_flag(w_idex),
    .exmem_flag(w_exmem), .memwb_flag(w_memwb),
    .redirect_valid(w_rv), .redirect_addr(w_ra),
    .stall_cnt(w_scnt), .timeout_err(w_terr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_req     = 1'b0;
    trap_addr    = '0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    div_start    = 1'b0;
    div_done     = 1'b0;
    jump_req     = 1'b0;
    jump_addr    = '0;
    load_use_req = 1'b0;
    ifu_ready    = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_req = 1'b1;
    tick();
    #1;
    checks++;
    if (fl !== F_MEM) begin
      errors++;
      $display("FAIL rst_pre_memwait got %b exp %b", fl, F_MEM);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (fl !== F_RST) begin
      errors++;
      $display("FAIL rst_async_flags got %b exp %b", fl, F_RST);
    end
    checks++;
    if (rv !== 1'b0 || ra !== '0) begin
      errors++;
      $display("FAIL rst_redirect got %b/%h exp 0/0", rv, ra);
    end
    idle();
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (fl !== F_IDLE) begin
      errors++;
      $display("FAIL rst_release_flags got %b exp %b", fl, F_IDLE);
    end
    checks++;
    if (scnt !== '0 || terr !== 1'b0) begin
      errors++;
      $display("FAIL rst_counters got %0d/%b exp 0/0", scnt, terr);
    end
    tick();
    checks++;
    if (fl !== F_IDLE || scnt !== '0) begin
      errors++;
      $display("FAIL rst_idle_run got %b/%0d exp %b/0", fl, scnt, F_IDLE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_req = 1'b1;
    #2;
    checks++;
    if (fl !== F_LU) begin
      errors++;
      $display("FAIL lu_flags got %b exp %b", fl, F_LU);
    end
    tick();
    load_use_req = 1'b0;
    #2;
    checks++;
    if (fl !== F_IDLE) begin
      errors++;
      $display("FAIL lu_release got %b exp %b", fl, F_IDLE);
    end
    checks++;
    if (scnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_stall_cnt got %0d exp 1", scnt);
    end
    tick();
    ifu_ready = 1'b0;
    #2;
    checks++;
    if (fl !== F_FW) begin
      errors++;
      $display("FAIL fetch_wait got %b exp %b", fl, F_FW);
    end
    tick();
    ifu_ready = 1'b1;
    #2;
    checks++;
    if (scnt !== 32'd2) begin
      errors++;
      $display("FAIL fw_stall_cnt got %0d exp 2", scnt);
    end
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    jump_req     = 1'b1;
    jump_addr    = 64'h8000_0100;
    load_use_req = 1'b1;
    ifu_ready    = 1'b0;
    #2;
    checks++;
    if (fl !== F_JMP) begin
      errors++;
      $display("FAIL jump_flags got %b exp %b", fl, F_JMP);
    end
    checks++;
    if (rv !== 1'b1 || ra !== 64'h8000_0100) begin
      errors++;
      $display("FAIL jump_redirect got %b/%h exp 1/80000100", rv, ra);
    end
    tick();
    idle();
    jump_addr = 64'hdead_beef;
    #2;
    checks++;
    if (rv !== 1'b0 || ra !== '0) begin
      errors++;
      $display("FAIL jump_addr_zero got %b/%h exp 0/0", rv, ra);
    end
    checks++;
    if (scnt !== '0) begin
      errors++;
      $display("FAIL jump_no_stall got %0d exp 0", scnt);
    end
    tick();
  endtask

  task automatic test_div();
    do_reset();
    trap_addr = 64'h0000_0000_0000_1000;
    for (int c = 0; c <= 35; c++) begin
      div_start = (c == 0);
      div_done  = (c == 34);
      trap_req  = (c >= 5);
      #2;
      if (c <= 33) begin
        checks++;
        if (fl !== F_DIV || rv !== 1'b0) begin
          errors++;
          $display("FAIL div_busy c=%0d got %b/%b exp %b/0", c, fl, rv, F_DIV);
        end
      end else if (c == 34) begin
        checks++;
        if (fl !== F_IDLE || rv !== 1'b0) begin
          errors++;
          $display("FAIL div_done got %b/%b exp %b/0", fl, rv, F_IDLE);
        end
      end else begin
        checks++;
        if (fl !== F_TRAP) begin
          errors++;
          $display("FAIL div_trap_flags got %b exp %b", fl, F_TRAP);
        end
        checks++;
        if (rv !== 1'b1 || ra !== 64'h1000) begin
          errors++;
          $display("FAIL div_trap_redirect got %b/%h exp 1/1000", rv, ra);
        end
        checks++;
        if (scnt !== 32'd34) begin
          errors++;
          $display("FAIL div_stall_cnt got %0d exp 34", scnt);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      mem_ready = (c == 3);
      mem_req   = (c <= 3);
      #2;
      if (c <= 2) begin
        checks++;
        if (fl !== F_MEM) begin
          errors++;
          $display("FAIL mem_wait c=%0d got %b exp %b", c, fl, F_MEM);
        end
      end else begin
        checks++;
        if (fl !== F_IDLE) begin
          errors++;
          $display("FAIL mem_release c=%0d got %b exp %b", c, fl, F_IDLE);
        end
      end
      tick();
    end
    checks++;
    if (scnt !== 32'd3) begin
      errors++;
      $display("FAIL mem_stall_cnt got %0d exp 3", scnt);
    end
    idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      div_start = (c == 0);
      #2;
      if (c <= 6) begin
        checks++;
        if (wfl !== F_DIV || w_terr !== 1'b0) begin
          errors++;
          $display("FAIL wd_busy c=%0d got %b/%b exp %b/0", c, wfl, w_terr, F_DIV);
        end
      end else if (c == 7) begin
        checks++;
        if (wfl !== F_TO) begin
          errors++;
          $display("FAIL wd_fire_flags got %b exp %b", wfl, F_TO);
        end
        checks++;
        if (w_terr !== 1'b1) begin
          errors++;
          $display("FAIL wd_fire_err got %b exp 1", w_terr);
        end
      end else begin
        checks++;
        if (wfl !== F_IDLE || w_terr !== 1'b1) begin
          errors++;
          $display("FAIL wd_after c=%0d got %b/%b exp %b/1", c, wfl, w_terr, F_IDLE);
        end
      end
      if (c == 8) begin
        checks++;
        if (w_scnt !== 32'd8) begin
          errors++;
          $display("FAIL wd_stall_cnt got %0d exp 8", w_scnt);
        end
      end
      tick();
    end
    rst = 1'b1;
    #2;
    checks++;
    if (w_terr !== 1'b0) begin
      errors++;
      $display("FAIL wd_err_clear got %b exp 0", w_terr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wd_done_wins();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      div_start = (c == 0);
      div_done  = (c == 7);
      #2;
      if (c == 7) begin
        checks++;
        if (wfl !== F_IDLE || w_terr !== 1'b0) begin
          errors++;
          $display("FAIL wd_done_wins got %b/%b exp %b/0", wfl, w_terr, F_IDLE);
        end
      end else if (c == 8) begin
        checks++;
        if (wfl !== F_IDLE || w_terr !== 1'b0 || w_scnt !== 32'd7) begin
          errors++;
          $display("FAIL wd_done_after got %b/%b/%0d exp %b/0/7",
                   wfl, w_terr, w_scnt, F_IDLE);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_jump();
    test_div();
    test_mem_wait();
    test_watchdog();
    test_wd_done_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
